fc32_to_sc16_arb: RTL and testbench
===================================

// Module: fc32_to_sc16_arb
//
// PURPOSE
//   Shares one pipelined float-to-fixed conversion lane between two AXI-Stream sources.
//   Each source carries complex fc32 samples (I/Q IEEE-754 single pairs).
//   Output is a single sc16 stream (Q1.15 I/Q) plus a source-id sideband.
//   Arbitration is packet-granular round robin.
//   Sits between host-side fc32 DMA streams and the sc16 radio TX datapath.
//   Also maintains a saturation event counter for host readback.
//
// PARAMETERS
//   QWIDTH    16  output width per component (Q1.15)
//   RADIX     15  fractional bits of the output
//   SAT_CNT_W 16  width of the saturation event counter
//
// PORTS
//   clk         in   1        clock
//   rst_n       in   1        asynchronous, active-low reset
//   i0_tdata    in   64       {I_fp32[63:32], Q_fp32[31:0]}, source 0
//   i0_tlast    in   1        end of packet, source 0
//   i0_tvalid   in   1        source 0 valid
//   i0_tready   out  1        source 0 ready
//   i1_tdata    in   64       as i0, source 1
//   i1_tlast    in   1        as i0, source 1
//   i1_tvalid   in   1        as i0, source 1
//   i1_tready   out  1        as i0, source 1
//   o_tdata     out  2*QWIDTH {I_q[31:16], Q_q[15:0]}
//   o_tlast     out  1        end of packet, passed through with its beat
//   o_tuser     out  1        source id of the beat (0/1)
//   o_tvalid    out  1        output valid
//   o_tready    in   1        output ready
//   clear_stats in   1        synchronous clear of sat_count
//   sat_count   out  SAT_CNT_W number of output beats with >=1 saturated component
//
// BEHAVIOUR
//   - Reset: FSM=IDLE, last_served=1, both pipe stages empty.
//     All outputs are 0: o_tvalid, i*_tready, o_tdata, o_tlast, o_tuser, sat_count.
//   - FSM states IDLE, GNT0, GNT1.
//     - IDLE: if only iN_tvalid is high, go to GNTN.
//     - IDLE, both valid: grant the source != last_served.
//     - IDLE, none valid: stay in IDLE.
//     - GNTN: hold the grant until a beat with iN_tlast is accepted.
//       Then set last_served=N and go to IDLE.
//     - No re-arbitration mid-packet. The IDLE cycle costs one bubble per packet.
//   - iN_tready = (state==GNTN) && (stage1 empty || stage1 advancing). Never high in IDLE.
//   - Pipeline has two stages.
//     - Stage 1 registers {I,Q,tlast,src}.
//     - Stage 2 registers the converted sc16 word and the saturation flag.
//     - Latency is exactly 2 clk from input handshake to o_tvalid, with o_tready high.
//     - Throughput is 1 beat/clk inside a packet.
//     - Under backpressure each stage holds its contents; no beat is lost or duplicated.
//   - Conversion, per component (value = (-1)^s * 1.m * 2^(e-127)):
//     - e==0 (zero/denormal) -> 0x0000.
//     - NaN -> 0x0000, not counted as saturation.
//     - +inf -> 0x7FFF, counted as saturation.
//     - -inf -> 0x8000, counted as saturation.
//     - |value| < 2^-15 -> 0x0000 (truncate toward zero; no rounding).
//     - Positive value >= 1.0 -> 0x7FFF, counted as saturation.
//     - Negative value < -1.0 -> 0x8000, counted as saturation.
//     - Exactly -1.0 -> 0x8000, not counted as saturation.
//     - Otherwise: magnitude = {1,m} shifted to RADIX fractional bits and truncated.
//       Negative results are two's complement.
//   - Shift arithmetic: signed, at least EBITS+2 bits wide.
//     Right shifts >= 24 yield 0; there is no wrap on large exponents.
//   - sat_count increments by 1 when a stage-2 beat with sat flag is accepted (o_tvalid && o_tready).
//     - Saturating at all-ones.
//     - clear_stats wins over a simultaneous increment.
//   - Async reset mid-packet drops all in-flight beats.
//     After release, arbitration restarts from IDLE. No partial packet is completed.
//
// STRUCTURE
//   - Shared package fc32_sc16_pkg holds:
//     - FP32 field widths (MBITS=23, EBITS=8) and EXP_BIAS=127.
//     - Q15_MAX=16'h7FFF and Q15_MIN=16'h8000.
//     - The FSM state encoding.
//   - One sub-module: fp32_to_q15_sat.
//     - Purely combinational; instantiated twice (I and Q) in stage 2.
//     - Outputs {q[QWIDTH-1:0], sat}.
//
// TESTING
//   1) src0 one beat {0x3F000000,0xBE800000} -> o_tdata 0x4000_E000, o_tuser 0, arrives 2 clk later.
//   2) {0x3F800000,0xBF800000} (+1.0,-1.0) -> 0x7FFF_8000, sat_count becomes 1.
//      {0x7F800000,0x7FC00000} (+inf,NaN) -> 0x7FFF_0000, sat_count becomes 2.
//   3) {0x00000001,0x37000000} (denormal, 2^-17) -> 0x0000_0000, sat_count unchanged.
//   4) Both sources hold 3-beat packets continuously valid:
//      o_tuser sequence 0,0,0,1,1,1,0,0,0; tlast on every 3rd beat; one bubble per packet.
//   5) Random o_tready (50%) over 1000 beats:
//      output equals scoreboard order, no drop/duplicate, i*_tready low while o stalls with pipe full.
//   6) Assert rst_n low after beat 2 of a 4-beat packet:
//      outputs 0 immediately; after release src1 packet is granted cleanly.
//      clear_stats together with a sat beat -> sat_count 0.

Source files
------------

// File: rtl/fc32_sc16_pkg.sv
// Shared constants and arbiter state encoding for the fc32 -> sc16 conversion lane.
package fc32_sc16_pkg;

    localparam int MBITS    = 23;
    localparam int EBITS    = 8;
    localparam int EXP_BIAS = 127;

    localparam logic [15:0] Q15_MAX = 16'h7FFF;
    localparam logic [15:0] Q15_MIN = 16'h8000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/fp32_to_q15_sat.sv
// Combinational IEEE-754 single to Q1.15 converter with saturation flag.
// Truncates toward zero; NaN maps to zero without flagging saturation.
module fp32_to_q15_sat
    import fc32_sc16_pkg::*;
#(
    parameter int QWIDTH = 16,
    parameter int RADIX  = 15
) (
    input  logic [31:0]       fp_i,
    output logic [QWIDTH-1:0] q_o,
    output logic              sat_o
);

    localparam int SHW = EBITS + 2;
    localparam int SHB = $clog2(MBITS + 1);
    localparam logic signed [SHW-1:0] SHIFT_AT_E0 = SHW'(EXP_BIAS + MBITS - RADIX);
    localparam logic signed [SHW-1:0] SHIFT_LIMIT = SHW'(MBITS + 1);
    localparam logic [QWIDTH-1:0]     QMAX        = QWIDTH'(Q15_MAX);
    localparam logic [QWIDTH-1:0]     QMIN        = QWIDTH'(Q15_MIN);

    logic                  sign;
    logic [EBITS-1:0]      expo;
    logic [MBITS-1:0]      mant;
    logic signed [SHW-1:0] rshift;
    logic [QWIDTH-1:0]     mag;

    assign sign   = fp_i[31];
    assign expo   = fp_i[MBITS +: EBITS];
    assign mant   = fp_i[MBITS-1:0];
    assign rshift = SHIFT_AT_E0 - $signed({2'b00, expo});

    always_comb begin
        q_o   = '0;
        sat_o = 1'b0;
        mag   = '0;
        if (expo == '1) begin
            if (mant == '0) begin
                q_o   = sign ? QMIN : QMAX;
                sat_o = 1'b1;
            end
        end else if (expo >= EBITS'(EXP_BIAS)) begin
            // |value| >= 1.0: only an exact -1.0 is representable
            q_o   = sign ? QMIN : QMAX;
            sat_o = !(sign && (expo == EBITS'(EXP_BIAS)) && (mant == '0));
        end else if ((expo != '0) && (rshift < SHIFT_LIMIT)) begin
            mag = QWIDTH'({1'b1, mant} >> rshift[SHB-1:0]);
            q_o = sign ? -mag : mag;
        end
    end

endmodule

// File: rtl/fc32_to_sc16_arb.sv
// Two-source packet round-robin arbiter feeding a 2-stage fc32 -> sc16 lane.
//   state   | meaning
//   IDLE    | no grant; pick a source (one bubble per packet)
//   GNT0    | source 0 owns the lane until its tlast beat is accepted
//   GNT1    | source 1 owns the lane until its tlast beat is accepted
module fc32_to_sc16_arb
    import fc32_sc16_pkg::*;
#(
    parameter int QWIDTH    = 16,
    parameter int RADIX     = 15,
    parameter int SAT_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [63:0]           i0_tdata,
    input  logic                  i0_tlast,
    input  logic                  i0_tvalid,
    output logic                  i0_tready,
    input  logic [63:0]           i1_tdata,
    input  logic                  i1_tlast,
    input  logic                  i1_tvalid,
    output logic                  i1_tready,
    output logic [2*QWIDTH-1:0]   o_tdata,
    output logic                  o_tlast,
    output logic                  o_tuser,
    output logic                  o_tvalid,
    input  logic                  o_tready,
    input  logic                  clear_stats,
    output logic [SAT_CNT_W-1:0]  sat_count
);

    arb_state_e           state_q;
    logic                 last_served_q;

    logic                 s1_valid_q;
    logic                 s1_last_q;
    logic                 s1_src_q;
    logic [31:0]          s1_i_q;
    logic [31:0]          s1_q_q;

    logic                 s2_valid_q;
    logic                 s2_last_q;
    logic                 s2_src_q;
    logic                 s2_sat_q;
    logic [2*QWIDTH-1:0]  s2_data_q;

    logic [SAT_CNT_W-1:0] sat_cnt_q;
    logic [SAT_CNT_W-1:0] sat_cnt_d;

    logic                 s2_free;
    logic                 s1_free;
    logic                 take0;
    logic                 take1;
    logic                 take;
    logic                 in_src;
    logic [63:0]          in_data;
    logic                 in_last;

    logic [QWIDTH-1:0]    conv_i;
    logic [QWIDTH-1:0]    conv_q;
    logic                 sat_i;
    logic                 sat_q;

    assign s2_free   = !s2_valid_q || o_tready;
    assign s1_free   = !s1_valid_q || s2_free;
    assign i0_tready = (state_q == ST_GNT0) && s1_free;
    assign i1_tready = (state_q == ST_GNT1) && s1_free;
    assign take0     = i0_tvalid && i0_tready;
    assign take1     = i1_tvalid && i1_tready;
    assign take      = take0 || take1;
    assign in_src    = (state_q == ST_GNT1);
    assign in_data   = in_src ? i1_tdata : i0_tdata;
    assign in_last   = in_src ? i1_tlast : i0_tlast;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            last_served_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i0_tvalid && (!i1_tvalid || last_served_q)) begin
                        state_q <= ST_GNT0;
                    end else if (i1_tvalid) begin
                        state_q <= ST_GNT1;
                    end
                end
                ST_GNT0: begin
                    if (take0 && i0_tlast) begin
                        state_q       <= ST_IDLE;
                        last_served_q <= 1'b0;
                    end
                end
                ST_GNT1: begin
                    if (take1 && i1_tlast) begin
                        state_q       <= ST_IDLE;
                        last_served_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    fp32_to_q15_sat #(.QWIDTH(QWIDTH), .RADIX(RADIX)) u_conv_i (
        .fp_i  (s1_i_q),
        .q_o   (conv_i),
        .sat_o (sat_i)
    );

    fp32_to_q15_sat #(.QWIDTH(QWIDTH), .RADIX(RADIX)) u_conv_q (
        .fp_i  (s1_q_q),
        .q_o   (conv_q),
        .sat_o (sat_q)
    );

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (clear_stats) begin
            sat_cnt_d = '0;
        end else if (s2_valid_q && o_tready && s2_sat_q && (sat_cnt_q != '1)) begin
            sat_cnt_d = sat_cnt_q + SAT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_src_q   <= 1'b0;
            s1_i_q     <= '0;
            s1_q_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_src_q   <= 1'b0;
            s2_sat_q   <= 1'b0;
            s2_data_q  <= '0;
            sat_cnt_q  <= '0;
        end else begin
            if (s1_free) begin
                s1_valid_q <= take;
                if (take) begin
                    s1_i_q    <= in_data[63:32];
                    s1_q_q    <= in_data[31:0];
                    s1_last_q <= in_last;
                    s1_src_q  <= in_src;
                end
            end
            if (s2_free) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q <= {conv_i, conv_q};
                    s2_sat_q  <= sat_i || sat_q;
                    s2_last_q <= s1_last_q;
                    s2_src_q  <= s1_src_q;
                end
            end
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign o_tvalid  = s2_valid_q;
    assign o_tdata   = s2_data_q;
    assign o_tlast   = s2_last_q;
    assign o_tuser   = s2_src_q;
    assign sat_count = sat_cnt_q;

endmodule

// File: tb/tb_fc32_to_sc16_arb.sv
// Scoreboard bench for fc32_to_sc16_arb: real-valued reference conversion,
// queue of expected beats in handshake order, decoupled output monitor.
module tb_fc32_to_sc16_arb;

    localparam int TMO = 2000;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        user;
        logic        sat;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [63:0] i0_tdata;
    logic        i0_tlast;
    logic        i0_tvalid;
    logic        i0_tready;
    logic [63:0] i1_tdata;
    logic        i1_tlast;
    logic        i1_tvalid;
    logic        i1_tready;
    logic [31:0] o_tdata;
    logic        o_tlast;
    logic        o_tuser;
    logic        o_tvalid;
    logic        o_tready;
    logic        clear_stats;
    logic [15:0] sat_count;

    int          n_cmp;
    int          n_fail;
    int          n_out;
    int          cyc;
    logic [15:0] exp_sat;
    logic [31:0] last_out;
    bit          recording;
    bit          rand_rdy;
    exp_t        sb_q[$];
    bit          rec_user[$];
    bit          rec_last[$];
    int          rec_cyc[$];

    fc32_to_sc16_arb dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i0_tdata    (i0_tdata),
        .i0_tlast    (i0_tlast),
        .i0_tvalid   (i0_tvalid),
        .i0_tready   (i0_tready),
        .i1_tdata    (i1_tdata),
        .i1_tlast    (i1_tlast),
        .i1_tvalid   (i1_tvalid),
        .i1_tready   (i1_tready),
        .o_tdata     (o_tdata),
        .o_tlast     (o_tlast),
        .o_tuser     (o_tuser),
        .o_tvalid    (o_tvalid),
        .o_tready    (o_tready),
        .clear_stats (clear_stats),
        .sat_count   (sat_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever @(posedge clk) cyc++;
    end

    // Reference conversion from the numeric value: returns {q16, sat}
    function automatic logic [16:0] ref_conv(input logic [31:0] f);
        int  ex;
        int  mt;
        int  qi;
        real v;
        ex = int'(f[30:23]);
        mt = int'(f[22:0]);
        if (ex == 0) return 17'h0;
        if (ex == 255) begin
            if (mt != 0) return 17'h0;
            return f[31] ? {16'h8000, 1'b1} : {16'h7FFF, 1'b1};
        end
        v = 1.0 + real'(mt) / 8388608.0;
        for (int k = 0; k < ex - 127; k++) v = v * 2.0;
        for (int k = 0; k < 127 - ex; k++) v = v / 2.0;
        if (f[31]) v = -v;
        if (v >= 1.0) return {16'h7FFF, 1'b1};
        if (v < -1.0) return {16'h8000, 1'b1};
        if (v == -1.0) return {16'h8000, 1'b0};
        qi = $rtoi(v * 32768.0);
        return {16'(qi), 1'b0};
    endfunction

    function automatic exp_t mk_exp(input logic [63:0] d, input logic last, input logic src);
        exp_t        e;
        logic [16:0] ci;
        logic [16:0] cq;
        ci     = ref_conv(d[63:32]);
        cq     = ref_conv(d[31:0]);
        e.data = {ci[16:1], cq[16:1]};
        e.last = last;
        e.user = src;
        e.sat  = ci[0] | cq[0];
        return e;
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [31:0] f;
        int          r;
        logic        s;
        r = $urandom_range(0, 9);
        s = 1'($urandom_range(0, 1));
        case (r)
            0:       f = {s, 8'h00, 23'($urandom)};
            1:       f = {s, 8'hFF, 23'h0};
            2:       f = {s, 8'hFF, 23'($urandom) | 23'h1};
            3:       f = {s, 8'd127, 23'h0};
            default: f = {s, 8'($urandom_range(100, 130)), 23'($urandom)};
        endcase
        return f;
    endfunction

    // Monitor: output compare, stall rule, then record new input handshakes
    initial begin
        exp_t e;
        int   inflight;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                inflight = sb_q.size();
                if (o_tvalid && !o_tready && inflight == 2) begin
                    n_cmp++;
                    if (i0_tready || i1_tready) begin
                        n_fail++;
                        $display("FAIL stall_ready: i0_tready=%0b i1_tready=%0b required 0/0", i0_tready, i1_tready);
                    end
                end
                if (o_tvalid && o_tready) begin
                    n_out++;
                    n_cmp++;
                    if (sb_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_beat: got data=0x%08h with no beat expected", o_tdata);
                    end else begin
                        e = sb_q.pop_front();
                        if (o_tdata !== e.data || o_tlast !== e.last || o_tuser !== e.user) begin
                            n_fail++;
                            $display("FAIL beat: got data=0x%08h last=%0b user=%0b required data=0x%08h last=%0b user=%0b",
                                     o_tdata, o_tlast, o_tuser, e.data, e.last, e.user);
                        end
                        if (!clear_stats && e.sat && exp_sat != 16'hFFFF) exp_sat++;
                    end
                    last_out = o_tdata;
                    if (recording) begin
                        rec_user.push_back(o_tuser);
                        rec_last.push_back(o_tlast);
                        rec_cyc.push_back(cyc);
                    end
                end
                if (clear_stats) exp_sat = '0;
                if (i0_tvalid && i0_tready) sb_q.push_back(mk_exp(i0_tdata, i0_tlast, 1'b0));
                if (i1_tvalid && i1_tready) sb_q.push_back(mk_exp(i1_tdata, i1_tlast, 1'b1));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_rdy) o_tready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #600000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the accepting edge with valid still high
    task automatic send_beat(input int src, input logic [63:0] d, input logic last);
        int   n;
        logic hs;
        n  = 0;
        hs = 1'b0;
        if (src == 0) begin
            i0_tdata = d; i0_tlast = last; i0_tvalid = 1'b1;
        end else begin
            i1_tdata = d; i1_tlast = last; i1_tvalid = 1'b1;
        end
        while (!hs && n < TMO) begin
            @(negedge clk);
            hs = (src == 0) ? i0_tready : i1_tready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!hs) begin
            n_cmp++;
            n_fail++;
            $display("FAIL handshake_timeout: src %0d got no tready in %0d cycles", src, TMO);
        end
    endtask

    task automatic drop_valid(input int src);
        if (src == 0) i0_tvalid = 1'b0;
        else          i1_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int src, input int len);
        for (int b = 0; b < len; b++) send_beat(src, {rnd_fp(), rnd_fp()}, b == len - 1);
        drop_valid(src);
    endtask

    task automatic one_beat(input int src, input logic [63:0] d);
        send_beat(src, d, 1'b1);
        drop_valid(src);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: %0d beats still expected, required 0", sb_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic src_random(input int src, input int nbeats);
        int sent;
        int len;
        int gap;
        sent = 0;
        while (sent < nbeats) begin
            len = $urandom_range(1, 8);
            if (len > nbeats - sent) len = nbeats - sent;
            send_pkt(src, len);
            sent += len;
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_o_tvalid"},  64'(o_tvalid),  64'h0);
        chk({tag, "_i0_tready"}, 64'(i0_tready), 64'h0);
        chk({tag, "_i1_tready"}, 64'(i1_tready), 64'h0);
        chk({tag, "_o_tdata"},   64'(o_tdata),   64'h0);
        chk({tag, "_o_tlast"},   64'(o_tlast),   64'h0);
        chk({tag, "_o_tuser"},   64'(o_tuser),   64'h0);
        chk({tag, "_sat_count"}, 64'(sat_count), 64'h0);
    endtask

    initial begin
        int base;
        n_cmp = 0; n_fail = 0; n_out = 0;
        exp_sat = '0; last_out = '0;
        recording = 1'b0; rand_rdy = 1'b0;
        rst_n = 1'b0;
        i0_tdata = '0; i0_tlast = 1'b0; i0_tvalid = 1'b0;
        i1_tdata = '0; i1_tlast = 1'b0; i1_tvalid = 1'b0;
        o_tready = 1'b1; clear_stats = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 1) basic conversion and two-cycle latency
        send_beat(0, {32'h3F000000, 32'hBE800000}, 1'b1);
        drop_valid(0);
        @(negedge clk);
        chk("latency_cycle1_o_tvalid", 64'(o_tvalid), 64'h0);
        @(negedge clk);
        chk("latency_cycle2_o_tvalid", 64'(o_tvalid), 64'h1);
        chk("t1_o_tuser", 64'(o_tuser), 64'h0);
        drain();
        chk("t1_data", 64'(last_out), 64'h4000E000);

        // 2) +1.0/-1.0 then +inf/NaN
        one_beat(0, {32'h3F800000, 32'hBF800000});
        drain();
        chk("t2a_data", 64'(last_out), 64'h7FFF8000);
        chk("t2a_sat_count", 64'(sat_count), 64'h1);
        one_beat(0, {32'h7F800000, 32'h7FC00000});
        drain();
        chk("t2b_data", 64'(last_out), 64'h7FFF0000);
        chk("t2b_sat_count", 64'(sat_count), 64'h2);

        // 3) denormal and below one LSB
        one_beat(0, {32'h00000001, 32'h37000000});
        drain();
        chk("t3_data", 64'(last_out), 64'h00000000);
        chk("t3_sat_count", 64'(sat_count), 64'h2);

        // src1 single beat: -inf and a negative in-range value
        one_beat(1, {32'hFF800000, 32'hBF400000});
        drain();
        chk("src1_data", 64'(last_out), 64'h8000A000);
        chk("src1_sat_count", 64'(sat_count), 64'h3);

        // 4) both sources continuously valid with 3-beat packets
        recording = 1'b1;
        fork
            begin send_pkt(0, 3); send_pkt(0, 3); end
            begin send_pkt(1, 3); send_pkt(1, 3); end
        join
        drain();
        recording = 1'b0;
        chk("t4_beat_count", 64'(rec_user.size()), 64'd12);
        if (rec_user.size() == 12) begin
            for (int k = 0; k < 12; k++) begin
                chk($sformatf("t4_user_%0d", k), 64'(rec_user[k]), 64'((k / 3) % 2));
                chk($sformatf("t4_last_%0d", k), 64'(rec_last[k]), 64'(k % 3 == 2));
                if (k > 0)
                    chk($sformatf("t4_gap_%0d", k), 64'(rec_cyc[k] - rec_cyc[k-1]), (k % 3 == 0) ? 64'd2 : 64'd1);
            end
        end

        // 5) random backpressure over 1000 beats
        rand_rdy = 1'b1;
        base = n_out;
        fork
            src_random(0, 500);
            src_random(1, 500);
        join
        rand_rdy = 1'b0;
        o_tready = 1'b1;
        drain();
        chk("t5_beat_count", 64'(n_out - base), 64'd1000);
        chk("t5_sat_count", 64'(sat_count), 64'(exp_sat));

        // 6a) clear_stats coincident with an accepted saturated beat
        send_beat(0, {32'h7F800000, 32'h00000000}, 1'b1);
        drop_valid(0);
        @(posedge clk);
        #1;
        clear_stats = 1'b1;
        @(posedge clk);
        #1;
        clear_stats = 1'b0;
        drain();
        chk("clear_wins_sat_count", 64'(sat_count), 64'h0);
        one_beat(0, {32'h40000000, 32'h00000000});
        drain();
        chk("after_clear_sat_count", 64'(sat_count), 64'h1);

        // 6b) reset after beat 2 of a 4-beat packet
        send_beat(0, {32'h3F000000, 32'h3F000000}, 1'b0);
        send_beat(0, {32'h3E800000, 32'h3E800000}, 1'b0);
        rst_n = 1'b0;
        i0_tvalid = 1'b0;
        sb_q.delete();
        exp_sat = '0;
        #1;
        chk_all_zero("midpkt_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        base = n_out;
        send_beat(1, {32'hBF000000, 32'h3E000000}, 1'b0);
        send_beat(1, {32'h3F7FFFFF, 32'hC0000000}, 1'b1);
        drop_valid(1);
        drain();
        chk("post_reset_beats", 64'(n_out - base), 64'd2);
        chk("post_reset_last_data", 64'(last_out), 64'h7FFF8000);
        chk("post_reset_sat_count", 64'(sat_count), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
